freq_meter: RTL and testbench

Gated frequency meter for the irrigation controller's clock tree. It samples an asynchronous slow signal, such as `sprinkler_clk`, `drip_clk`, `fill_clk` or `clk_1hz`, on the 864 Hz system clock. It counts rising edges over a fixed gate window and reports the count once per window. It sits downstream of the frequency divider and is the checking end of that clock chain: it is used on the board and in benches to confirm each derived rate.

---
 rtl/freq_meter.sv | 135 +++++++++++++
 tb/tb_freq_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Optional period measurement between successive edges is enabled with `define FREQ_METER_PERIOD_EN.
module freq_meter #(
  parameter int GATE_CYCLES = 864,
  parameter int W           = 10,
  parameter int PW          = 16
) (
  input  logic          clk_864hz,
  input  logic          limpa,
  input  logic          en,
  input  logic          sig_in,
  output logic [W-1:0]  freq_count,
  output logic          count_valid,
  output logic          sat,
  output logic [PW-1:0] period,
  output logic          period_valid
);
  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t        state_q;
  logic          s1_q, s2_q, s3_q;
  logic [GW-1:0] gate_q;
  logic [W-1:0]  edge_q, edge_d;
  logic          flag_q;
  logic [W-1:0]  freq_q;
  logic          cv_q, sat_q;
  logic          strobe;
  logic [W:0]    edge_sum;
  logic          edge_ovf;

  assign strobe   = s2_q & ~s3_q;
  assign edge_sum = {1'b0, edge_q} + (W+1)'(strobe);
  assign edge_ovf = edge_sum[W];
  // Saturate instead of wrapping so an over-range input still reads as full scale.
  assign edge_d   = edge_ovf ? {W{1'b1}} : edge_sum[W-1:0];

  always_ff @(posedge clk_864hz) begin
    if (limpa) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      gate_q  <= '0;
      edge_q  <= '0;
      flag_q  <= 1'b0;
      freq_q  <= '0;
      cv_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      cv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_q <= '0;
          edge_q <= '0;
          flag_q <= 1'b0;
          if (en) state_q <= MEASURE;
        end
        MEASURE: begin
          if (!en) begin
            state_q <= IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            flag_q  <= 1'b0;
          end else if (gate_q == GATE_LAST) begin
            // A strobe in the closing cycle belongs to the closing window.
            gate_q <= '0;
            edge_q <= '0;
            flag_q <= 1'b0;
            freq_q <= edge_d;
            sat_q  <= flag_q | edge_ovf;
            cv_q   <= 1'b1;
          end else begin
            gate_q <= gate_q + GW'(1);
            edge_q <= edge_d;
            flag_q <= flag_q | edge_ovf;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign freq_count  = freq_q;
  assign count_valid = cv_q;
  assign sat         = sat_q;

`ifdef FREQ_METER_PERIOD_EN
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [PW:0]   p_sum;
  logic          armed_q;
  logic [PW-1:0] per_q;
  logic          pv_q;

  assign p_sum  = {1'b0, pcnt_q} + (PW+1)'(1);
  assign pcnt_d = p_sum[PW] ? {PW{1'b1}} : p_sum[PW-1:0];

  always_ff @(posedge clk_864hz) begin
    if (limpa) begin
      pcnt_q  <= '0;
      armed_q <= 1'b0;
      per_q   <= '0;
      pv_q    <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (state_q != MEASURE) begin
        pcnt_q  <= '0;
        armed_q <= 1'b0;
      end else if (strobe) begin
        // The first edge after entering MEASURE only arms the counter.
        if (armed_q) begin
          per_q <= pcnt_d;
          pv_q  <= 1'b1;
        end
        pcnt_q  <= '0;
        armed_q <= 1'b1;
      end else begin
        pcnt_q <= pcnt_d;
      end
    end
  end

  assign period       = per_q;
  assign period_valid = pv_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: default instance plus a W=4 instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_freq_meter;
  logic clk = 1'b0;
  logic limpa, en;
  logic sig_in = 1'b0;
  logic [9:0]  fc0;
  logic        cv0, sat0, pv0;
  logic [15:0] per0;
  logic [3:0]  fc4;
  logic        cv4, sat4, pv4;
  logic [15:0] per4;

  int n_chk = 0;
  int n_fail = 0;

  int   tog_n = 0;
  logic hold_v = 1'b0;
  int   epoch = 0;
  int   seen = 0;
  int   tcnt = 0;

  freq_meter u0 (
    .clk_864hz(clk), .limpa(limpa), .en(en), .sig_in(sig_in),
    .freq_count(fc0), .count_valid(cv0), .sat(sat0),
    .period(per0), .period_valid(pv0)
  );

  freq_meter #(.GATE_CYCLES(864), .W(4), .PW(16)) u4 (
    .clk_864hz(clk), .limpa(limpa), .en(en), .sig_in(sig_in),
    .freq_count(fc4), .count_valid(cv4), .sat(sat4),
    .period(per4), .period_valid(pv4)
  );

  always #5 clk = ~clk;

  // Square-wave source: toggles sig_in every tog_n cycles, or holds hold_v when tog_n==0.
  always begin
    @(posedge clk);
    #2;
    if (epoch != seen) begin
      seen = epoch;
      tcnt = 0;
      sig_in = hold_v;
    end else if (tog_n != 0) begin
      tcnt++;
      if (tcnt >= tog_n) begin
        tcnt = 0;
        sig_in = ~sig_in;
      end
    end
  end

  task automatic set_sig(input int n, input logic v);
    tog_n = n;
    hold_v = v;
    epoch++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cv(input int budget, output int lat, output bit ok);
    lat = 0;
    ok = 1'b0;
    while (lat < budget && !ok) begin
      @(posedge clk);
      #1;
      lat++;
      if (cv0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    limpa = 1'b1;
    en = 1'b0;
    set_sig(0, 1'b0);
    tick(3);
    n_chk++; if (fc0 !== 10'd0) begin n_fail++; $display("FAIL reset_fc0: got %0d want 0", fc0); end
    n_chk++; if (cv0 !== 1'b0) begin n_fail++; $display("FAIL reset_cv0: got %b want 0", cv0); end
    n_chk++; if (sat0 !== 1'b0) begin n_fail++; $display("FAIL reset_sat0: got %b want 0", sat0); end
    n_chk++; if (per0 !== 16'd0) begin n_fail++; $display("FAIL reset_per0: got %0d want 0", per0); end
    n_chk++; if (pv0 !== 1'b0) begin n_fail++; $display("FAIL reset_pv0: got %b want 0", pv0); end
    n_chk++; if ({fc4, sat4, cv4} !== 6'd0) begin n_fail++; $display("FAIL reset_u4: got %h want 0", {fc4, sat4, cv4}); end
    limpa = 1'b0;
    tick(2);
  endtask

  task automatic test_27hz;
    int lat;
    bit ok;
    set_sig(16, 1'b0);
    en = 1'b1;
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || lat != 865) begin n_fail++; $display("FAIL 27hz_first_latency: got %0d want 865", lat); end
    n_chk++; if (fc0 !== 10'd27) begin n_fail++; $display("FAIL 27hz_count0: got %0d want 27", fc0); end
    n_chk++; if (sat0 !== 1'b0) begin n_fail++; $display("FAIL 27hz_sat0: got %b want 0", sat0); end
    n_chk++; if (fc4 !== 4'd15 || sat4 !== 1'b1) begin n_fail++; $display("FAIL 27hz_w4: got %0d/%b want 15/1", fc4, sat4); end
    tick(1);
    n_chk++; if (cv0 !== 1'b0) begin n_fail++; $display("FAIL 27hz_pulse_width: got %b want 0", cv0); end
    for (int i = 0; i < 2; i++) begin
      wait_cv(2000, lat, ok);
      n_chk++; if (!ok || lat != 863) begin n_fail++; $display("FAIL 27hz_interval: got %0d want 863", lat); end
      n_chk++; if (fc0 !== 10'd27) begin n_fail++; $display("FAIL 27hz_count: got %0d want 27", fc0); end
      if (i == 0) tick(1);
    end
  endtask

  task automatic test_constant;
    int lat;
    bit ok;
    en = 1'b0;
    set_sig(0, 1'b0);
    tick(4);
    en = 1'b1;
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || fc0 !== 10'd0) begin n_fail++; $display("FAIL const_low: got %0d want 0", fc0); end
    tick(400);
    set_sig(0, 1'b1);
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || fc0 !== 10'd1) begin n_fail++; $display("FAIL const_rise: got %0d want 1", fc0); end
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || fc0 !== 10'd0) begin n_fail++; $display("FAIL const_high: got %0d want 0", fc0); end
  endtask

  task automatic test_saturation;
    int lat;
    bit ok;
    set_sig(4, 1'b0);
    wait_cv(2000, lat, ok);
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || fc4 !== 4'd15 || sat4 !== 1'b1) begin n_fail++; $display("FAIL sat_w4_108: got %0d/%b want 15/1", fc4, sat4); end
    n_chk++; if (fc0 !== 10'd108 || sat0 !== 1'b0) begin n_fail++; $display("FAIL sat_w10_108: got %0d/%b want 108/0", fc0, sat0); end
    set_sig(48, 1'b0);
    wait_cv(2000, lat, ok);
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || fc4 !== 4'd9 || sat4 !== 1'b0) begin n_fail++; $display("FAIL sat_w4_9: got %0d/%b want 9/0", fc4, sat4); end
    n_chk++; if (fc0 !== 10'd9) begin n_fail++; $display("FAIL sat_w10_9: got %0d want 9", fc0); end
  endtask

  task automatic test_abort;
    int lat;
    bit ok;
    int seen_cv;
    set_sig(16, 1'b0);
    wait_cv(2000, lat, ok);
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || fc0 !== 10'd27) begin n_fail++; $display("FAIL abort_pre: got %0d want 27", fc0); end
    tick(500);
    en = 1'b0;
    seen_cv = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (cv0) seen_cv++;
    end
    n_chk++; if (seen_cv != 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen_cv); end
    n_chk++; if (fc0 !== 10'd27) begin n_fail++; $display("FAIL abort_hold: got %0d want 27", fc0); end
    en = 1'b1;
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || lat != 865) begin n_fail++; $display("FAIL abort_restart_latency: got %0d want 865", lat); end
    n_chk++; if (fc0 !== 10'd27) begin n_fail++; $display("FAIL abort_restart_count: got %0d want 27", fc0); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    tick(300);
    limpa = 1'b1;
    tick(1);
    limpa = 1'b0;
    n_chk++; if ({fc0, cv0, sat0} !== 12'd0) begin n_fail++; $display("FAIL rstmid_outs: got %h want 0", {fc0, cv0, sat0}); end
    n_chk++; if ({per0, pv0} !== 17'd0) begin n_fail++; $display("FAIL rstmid_period: got %h want 0", {per0, pv0}); end
    wait_cv(2000, lat, ok);
    n_chk++; if (!ok || lat + 1 != 866) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 866", lat + 1); end
  endtask

  task automatic test_period;
    int lat;
    limpa = 1'b1;
    set_sig(0, 1'b0);
    tick(3);
    limpa = 1'b0;
    en = 1'b1;
    set_sig(432, 1'b0);
`ifdef FREQ_METER_PERIOD_EN
    lat = 0;
    while (lat < 3000 && !pv0) begin tick(1); lat++; end
    n_chk++; if (!pv0 || lat < 1000) begin n_fail++; $display("FAIL period_first: got pv=%b after %0d want pulse after second edge", pv0, lat); end
    n_chk++; if (per0 !== 16'd864) begin n_fail++; $display("FAIL period_val1: got %0d want 864", per0); end
    tick(1);
    lat = 1;
    while (lat < 2000 && !pv0) begin tick(1); lat++; end
    n_chk++; if (!pv0 || lat != 864) begin n_fail++; $display("FAIL period_interval: got %0d want 864", lat); end
    n_chk++; if (per0 !== 16'd864) begin n_fail++; $display("FAIL period_val2: got %0d want 864", per0); end
`else
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (pv0 || per0 != 16'd0) lat++;
    end
    n_chk++; if (lat != 0) begin n_fail++; $display("FAIL period_disabled: got %0d nonzero cycles want 0", lat); end
`endif
  endtask

  initial begin
    limpa = 1'b1;
    en = 1'b0;
    test_reset;
    test_27hz;
    test_constant;
    test_saturation;
    test_abort;
    test_reset_mid;
    test_period;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
